// File: rtl/peripheral_apb4_master_pkg.sv
// ============================================================================
// Module : peripheral_apb4_master_pkg
// Brief  : Shared types and constants for the APB4 master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package peripheral_apb4_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Bit positions within PPROT
    localparam int PROT_PRIV  = 0;
    localparam int PROT_NSEC  = 1;
    localparam int PROT_INSTR = 2;

endpackage

`default_nettype wire

// File: rtl/peripheral_apb4_master_if.sv
// ============================================================================
// Module : peripheral_apb4_master_if
// Brief  : Request/response and APB4 bus bundle for the APB4 master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface peripheral_apb4_master_if #(
    parameter int PDATA_SIZE = 32,
    parameter int PADDR_SIZE = 16
);
    logic                      req_valid;
    logic                      req_ready;
    logic [PADDR_SIZE-1:0]     req_addr;
    logic                      req_write;
    logic [PDATA_SIZE-1:0]     req_wdata;
    logic [PDATA_SIZE/8-1:0]   req_strb;
    logic [2:0]                req_prot;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [PDATA_SIZE-1:0]     rsp_rdata;
    logic                      rsp_err;

    logic                      PSEL;
    logic                      PENABLE;
    logic [PADDR_SIZE-1:0]     PADDR;
    logic                      PWRITE;
    logic [PDATA_SIZE-1:0]     PWDATA;
    logic [PDATA_SIZE/8-1:0]   PSTRB;
    logic [2:0]                PPROT;
    logic [PDATA_SIZE-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

`default_nettype wire

// File: rtl/peripheral_apb4_master_timeout.sv
// ============================================================================
// Module : peripheral_apb4_master_timeout
// Brief  : Saturating wait-state counter; o_expire once TIMEOUT_CYCLES counted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module peripheral_apb4_master_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);

    localparam int              c_CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT_CYCLES);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/peripheral_apb4_master.sv
// ============================================================================
// Module : peripheral_apb4_master
// Brief  : Valid/ready request/response to APB4 SETUP/ACCESS initiator.
//          Optional ACCESS timeout enabled by `define APB4_MASTER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module peripheral_apb4_master
    import peripheral_apb4_master_pkg::*;
#(
    parameter int PDATA_SIZE     = 32,
    parameter int PADDR_SIZE     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                PCLK,
    input  wire logic                PRESET,
    peripheral_apb4_master_if.master bus
);

    if (((PDATA_SIZE % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("peripheral_apb4_master: invalid PDATA_SIZE or TIMEOUT_CYCLES");
    end

    state_t                  r_state;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [PADDR_SIZE-1:0]   r_paddr;
    logic [PDATA_SIZE-1:0]   r_pwdata;
    logic [PDATA_SIZE/8-1:0] r_pstrb;
    logic [2:0]              r_pprot;
    logic                    r_rsp_valid;
    logic [PDATA_SIZE-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    state_t                  w_state_nxt;
    logic                    w_psel_nxt;
    logic                    w_penable_nxt;
    logic                    w_pwrite_nxt;
    logic [PADDR_SIZE-1:0]   w_paddr_nxt;
    logic [PDATA_SIZE-1:0]   w_pwdata_nxt;
    logic [PDATA_SIZE/8-1:0] w_pstrb_nxt;
    logic [2:0]              w_pprot_nxt;
    logic                    w_rsp_valid_nxt;
    logic [PDATA_SIZE-1:0]   w_rsp_rdata_nxt;
    logic                    w_rsp_err_nxt;

    logic                    w_req_ready;
    logic                    w_accept;
    logic                    w_timeout;

`ifdef APB4_MASTER_TIMEOUT_EN
    logic w_expire;

    // Counter is cleared during SETUP so it starts at zero on ACCESS entry
    peripheral_apb4_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_clear  (r_state == SETUP),
        .i_enable ((r_state == ACCESS) && !bus.PREADY),
        .o_expire (w_expire)
    );

    assign w_timeout = w_expire;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready);
    assign w_accept    = bus.req_valid && w_req_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        w_pprot_nxt     = r_pprot;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_state_nxt     = RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : bus.PRDATA;
                    w_rsp_err_nxt   = bus.PSLVERR;
                end else if (w_timeout) begin
                    w_state_nxt     = RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Acceptance is only possible from IDLE or a consumed RESP
        if (w_accept) begin
            w_state_nxt   = SETUP;
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
            w_paddr_nxt   = bus.req_addr;
            w_pwrite_nxt  = bus.req_write;
            w_pprot_nxt   = bus.req_prot;
            w_pstrb_nxt   = bus.req_write ? bus.req_strb : '0;
            if (bus.req_write) begin
                w_pwdata_nxt = bus.req_wdata;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
            r_pprot     <= w_pprot_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PADDR     = r_paddr;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PWDATA    = r_pwdata;
    assign bus.PSTRB     = r_pstrb;
    assign bus.PPROT     = r_pprot;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_apb4_master.sv
// ============================================================================
// Module : tb_peripheral_apb4_master
// Brief  : Directed self-checking bench for peripheral_apb4_master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_peripheral_apb4_master;
    import peripheral_apb4_master_pkg::*;

    localparam int PDATA_SIZE = 32;
    localparam int PADDR_SIZE = 16;

    logic PCLK;
    logic PRESET;
    int   n_checks;
    int   n_fail;

    peripheral_apb4_master_if #(.PDATA_SIZE(PDATA_SIZE), .PADDR_SIZE(PADDR_SIZE)) bus ();

    peripheral_apb4_master #(
        .PDATA_SIZE     (PDATA_SIZE),
        .PADDR_SIZE     (PADDR_SIZE),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive_req(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] prot);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        bus.req_prot  = prot;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.PSEL !== 1'b0)        begin n_fail++; $display("FAIL rst_psel: got %b want 0", bus.PSEL); end
        n_checks++; if (bus.PENABLE !== 1'b0)     begin n_fail++; $display("FAIL rst_penable: got %b want 0", bus.PENABLE); end
        n_checks++; if (bus.PWRITE !== 1'b0)      begin n_fail++; $display("FAIL rst_pwrite: got %b want 0", bus.PWRITE); end
        n_checks++; if (bus.rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_err !== 1'b0)     begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
        n_checks++; if (bus.PADDR !== 16'h0)      begin n_fail++; $display("FAIL rst_paddr: got %h want 0", bus.PADDR); end
        n_checks++; if (bus.PWDATA !== 32'h0)     begin n_fail++; $display("FAIL rst_pwdata: got %h want 0", bus.PWDATA); end
        n_checks++; if (bus.PSTRB !== 4'h0)       begin n_fail++; $display("FAIL rst_pstrb: got %h want 0", bus.PSTRB); end
        n_checks++; if (bus.PPROT !== 3'h0)       begin n_fail++; $display("FAIL rst_pprot: got %h want 0", bus.PPROT); end
        n_checks++; if (bus.rsp_rdata !== 32'h0)  begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        n_checks++; if (bus.req_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.rsp_ready = 1'b0;
        drive_req(16'h0002, 1'b1, 32'h0000_00A5, 4'hF, 3'(1 << PROT_NSEC));
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_req_ready_idle: got %b want 1", bus.req_ready); end
        tick();                                   // edge N
        bus.req_valid = 1'b0;
        n_checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b10) begin n_fail++; $display("FAIL wr_setup_sel_en: got %b want 10", {bus.PSEL, bus.PENABLE}); end
        n_checks++; if (bus.PADDR !== 16'h0002)   begin n_fail++; $display("FAIL wr_paddr: got %h want 0002", bus.PADDR); end
        n_checks++; if (bus.PWRITE !== 1'b1)      begin n_fail++; $display("FAIL wr_pwrite: got %b want 1", bus.PWRITE); end
        n_checks++; if (bus.PSTRB !== 4'hF)       begin n_fail++; $display("FAIL wr_pstrb: got %h want f", bus.PSTRB); end
        n_checks++; if (bus.PWDATA !== 32'hA5)    begin n_fail++; $display("FAIL wr_pwdata: got %h want 000000a5", bus.PWDATA); end
        n_checks++; if (bus.PPROT !== 3'b010)     begin n_fail++; $display("FAIL wr_pprot: got %b want 010", bus.PPROT); end
        n_checks++; if (bus.req_ready !== 1'b0)   begin n_fail++; $display("FAIL wr_req_ready_busy: got %b want 0", bus.req_ready); end
        tick();                                   // cycle N+2
        n_checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin n_fail++; $display("FAIL wr_access_sel_en: got %b want 11", {bus.PSEL, bus.PENABLE}); end
        n_checks++; if (bus.rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL wr_rsp_early: got %b want 0", bus.rsp_valid); end
        tick();                                   // cycle N+3
        n_checks++; if (bus.rsp_valid !== 1'b1)   begin n_fail++; $display("FAIL wr_rsp_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_err !== 1'b0)     begin n_fail++; $display("FAIL wr_rsp_err: got %b want 0", bus.rsp_err); end
        n_checks++; if (bus.rsp_rdata !== 32'h0)  begin n_fail++; $display("FAIL wr_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        n_checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin n_fail++; $display("FAIL wr_resp_sel_en: got %b want 00", {bus.PSEL, bus.PENABLE}); end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1)   begin n_fail++; $display("FAIL wr_req_ready_resp: got %b want 1", bus.req_ready); end
        tick();
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL wr_rsp_consumed: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_read_wait();
        bus.PREADY = 1'b0; bus.PRDATA = 32'h1234_5678;
        drive_req(16'h0003, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'(1 << PROT_PRIV));
        tick();                                   // edge N
        bus.req_valid = 1'b0;
        n_checks++; if (bus.PSTRB !== 4'h0)       begin n_fail++; $display("FAIL rd_pstrb_setup: got %h want 0", bus.PSTRB); end
        n_checks++; if (bus.PWDATA !== 32'hA5)    begin n_fail++; $display("FAIL rd_pwdata_hold: got %h want 000000a5", bus.PWDATA); end
        n_checks++; if (bus.PWRITE !== 1'b0)      begin n_fail++; $display("FAIL rd_pwrite: got %b want 0", bus.PWRITE); end
        tick();                                   // cycle N+2, first ACCESS cycle
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.PREADY = 1'b1;
            n_checks++; if ({bus.PSEL, bus.PENABLE, bus.PSTRB, bus.rsp_valid} !== 7'b11_0000_0)
                begin n_fail++; $display("FAIL rd_access_%0d: got sel/en/strb/rv %b want 1100000", i, {bus.PSEL, bus.PENABLE, bus.PSTRB, bus.rsp_valid}); end
            tick();
        end                                       // cycle N+6
        n_checks++; if (bus.rsp_valid !== 1'b1)   begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h want 12345678", bus.rsp_rdata); end
        n_checks++; if (bus.PENABLE !== 1'b0)     begin n_fail++; $display("FAIL rd_penable_drop: got %b want 0", bus.PENABLE); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_error();
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
        drive_req(16'h0007, 1'b1, 32'hDEAD_0007, 4'h3, 3'b000);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        bus.PSLVERR = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b1)   begin n_fail++; $display("FAIL err_rsp_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_err !== 1'b1)     begin n_fail++; $display("FAIL err_rsp_err: got %b want 1", bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.PREADY = 1'b1; bus.PRDATA = 32'hCAFE_F00D;
        drive_req(16'h0010, 1'b1, 32'h0000_1111, 4'h1, 3'(1 << PROT_INSTR));
        tick();
        bus.req_valid = 1'b0;
        tick();
        n_checks++; if (bus.PSEL !== 1'b1)        begin n_fail++; $display("FAIL b2b_psel_access: got %b want 1", bus.PSEL); end
        tick();                                   // RESP of first transfer
        n_checks++; if (bus.rsp_err !== 1'b0)     begin n_fail++; $display("FAIL b2b_err_cleared: got %b want 0", bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        drive_req(16'h0020, 1'b0, 32'h0, 4'h0, 3'b000);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1)   begin n_fail++; $display("FAIL b2b_req_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (bus.PSEL !== 1'b0)        begin n_fail++; $display("FAIL b2b_psel_gap: got %b want 0", bus.PSEL); end
        tick();
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        n_checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b10) begin n_fail++; $display("FAIL b2b_setup: got %b want 10", {bus.PSEL, bus.PENABLE}); end
        n_checks++; if (bus.PADDR !== 16'h0020)   begin n_fail++; $display("FAIL b2b_paddr: got %h want 0020", bus.PADDR); end
        n_checks++; if (bus.rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL b2b_rsp_drop: got %b want 0", bus.rsp_valid); end
        tick();
        tick();
        n_checks++; if (bus.rsp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_rdata: got %h want cafef00d", bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.PREADY = 1'b1; bus.PRDATA = 32'h0BAD_BEEF;
        drive_req(16'h0004, 1'b0, 32'h0, 4'h0, 3'b000);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        bus.PRDATA = 32'h5555_AAAA;
        drive_req(16'h0044, 1'b1, 32'h9999_9999, 4'hF, 3'b000);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if ({bus.rsp_valid, bus.req_ready, bus.PSEL} !== 3'b100 || bus.rsp_rdata !== 32'h0BAD_BEEF)
                begin n_fail++; $display("FAIL bp_hold_%0d: got rv/rr/sel %b rdata %h want 100 0badbeef", i, {bus.rsp_valid, bus.req_ready, bus.PSEL}, bus.rsp_rdata); end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        n_checks++; if ({bus.rsp_valid, bus.PSEL} !== 2'b00) begin n_fail++; $display("FAIL bp_release: got rv/sel %b want 00", {bus.rsp_valid, bus.PSEL}); end
    endtask

    task automatic test_reset_mid();
        bus.PREADY = 1'b0;
        drive_req(16'h0005, 1'b1, 32'h0000_5555, 4'hF, 3'b111);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.PENABLE !== 1'b1)     begin n_fail++; $display("FAIL rm_in_access: got %b want 1", bus.PENABLE); end
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        bus.PREADY = 1'b1;
        n_checks++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL rm_after_rst: got sel/en/rv %b want 000", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
        n_checks++; if (bus.PWDATA !== 32'h0)     begin n_fail++; $display("FAIL rm_pwdata: got %h want 0", bus.PWDATA); end
        tick();
        tick();
        n_checks++; if ({bus.PSEL, bus.rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rm_no_resp: got sel/rv %b want 00", {bus.PSEL, bus.rsp_valid}); end
    endtask

    task automatic test_stuck_pready();
        bus.PREADY = 1'b0;
        drive_req(16'h0006, 1'b0, 32'h0, 4'h0, 3'b000);
        bus.PRDATA = 32'h7777_7777;
        tick();
        bus.req_valid = 1'b0;
        tick();                                   // first ACCESS cycle
`ifdef APB4_MASTER_TIMEOUT_EN
        for (int i = 0; i <= 16; i++) begin
            n_checks++; if ({bus.PENABLE, bus.rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL to_wait_%0d: got en/rv %b want 10", i, {bus.PENABLE, bus.rsp_valid}); end
            tick();
        end
        n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.PSEL} !== 3'b110) begin n_fail++; $display("FAIL to_expire: got rv/err/sel %b want 110", {bus.rsp_valid, bus.rsp_err, bus.PSEL}); end
        n_checks++; if (bus.rsp_rdata !== 32'h0)  begin n_fail++; $display("FAIL to_rdata: got %h want 0", bus.rsp_rdata); end
`else
        for (int i = 0; i < 40; i++) begin
            n_checks++; if ({bus.PENABLE, bus.rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL stuck_wait_%0d: got en/rv %b want 10", i, {bus.PENABLE, bus.rsp_valid}); end
            tick();
        end
        bus.PREADY = 1'b1;
        tick();
        n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin n_fail++; $display("FAIL stuck_resp: got rv/err %b want 10", {bus.rsp_valid, bus.rsp_err}); end
        n_checks++; if (bus.rsp_rdata !== 32'h7777_7777) begin n_fail++; $display("FAIL stuck_rdata: got %h want 77777777", bus.rsp_rdata); end
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        PRESET        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_error();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_stuck_pready();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/peripheral_apb4_master.md
Name: peripheral_apb4_master

Overview:
APB4 initiator that converts a simple valid/ready request/response interface into APB4 SETUP/ACCESS transfers. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT and honours PREADY wait states and PSLVERR. It sits between a BFM or DMA control engine and APB4 peripherals such as the GPIO slave. It handles one outstanding transfer at a time.

Parameters:
PDATA_SIZE, 32, data width; must be a multiple of 8
PADDR_SIZE, 16, address width
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY; used only with the optional feature

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted this cycle when high together with req_valid
req_addr  in  PADDR_SIZE  transfer address
req_write  in  1  1 = write, 0 = read
req_wdata  in  PDATA_SIZE  write data
req_strb  in  PDATA_SIZE/8  byte strobes; ignored for reads
req_prot  in  3  protection attributes, forwarded to PPROT
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  PDATA_SIZE  read data; 0 for writes
rsp_err  out  1  PSLVERR or timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  PADDR_SIZE  APB address
PWRITE  out  1  APB direction
PWDATA  out  PDATA_SIZE  APB write data
PSTRB  out  PDATA_SIZE/8  APB strobes
PPROT  out  3  APB protection
PRDATA  in  PDATA_SIZE  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset (PRESET high at a PCLK edge): state = IDLE; PSEL, PENABLE, PWRITE, rsp_valid and rsp_err = 0; PADDR, PWDATA, PSTRB, PPROT and rsp_rdata = 0. Reset mid-transfer abandons the transfer immediately; no response is produced.
- States: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- req_ready = (state == IDLE) | (state == RESP & rsp_ready). This is combinational and has no dependency on req_valid.
- Accept (req_valid & req_ready):
  - Register PADDR, PWRITE and PPROT.
  - PWDATA = req_wdata for writes; PWDATA holds its previous value for reads.
  - PSTRB = req_strb for writes; PSTRB = 0 for reads (APB4 rule).
  - Go to SETUP with PSEL=1, PENABLE=0.
- SETUP: one cycle, then ACCESS with PENABLE=1. Address and control stay stable.
- ACCESS with PREADY=0: hold all APB outputs (wait state).
- ACCESS with PREADY=1:
  - Drop PSEL and PENABLE to 0.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - rsp_err = PSLVERR.
  - Go to RESP with rsp_valid=1.
- RESP: hold rsp_* until rsp_ready.
  - rsp_ready without a new request: go to IDLE, rsp_valid=0.
  - rsp_ready with req_valid: accept the new request in the same cycle and go straight to SETUP. PSEL is 0 for exactly the RESP cycle.
- Latency: accept at edge N; SETUP in cycle N+1; ACCESS in N+2. With PREADY=1, rsp_valid is high from N+3. Each wait state adds 1 cycle.
- Requests arriving while busy are not accepted (req_ready=0). The request must be held stable by the requester until it is accepted.

Optional Feature:
APB4_MASTER_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0: PSEL and PENABLE go to 0, go to RESP with rsp_err=1 and rsp_rdata=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package peripheral_apb4_master_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - PPROT bit constants (PROT_PRIV=0, PROT_NSEC=1, PROT_INSTR=2).
- Sub-module peripheral_apb4_master_timeout: wait-state counter with clear/enable inputs and an expire output. It is instantiated only under the macro.

Test Plan:
- Write, zero wait: req addr=0x0002, wdata=0x000000A5, strb=0xF, PREADY=1 -> PSEL rises at N+1 and PENABLE at N+2 with PADDR=0x0002, PWRITE=1, PSTRB=0xF; rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: addr=0x0003, slave drives PRDATA=0x12345678 with PREADY low for 3 ACCESS cycles -> PSTRB=0 throughout; PENABLE high for 4 cycles; rsp_rdata=0x12345678 at N+6.
- Error: write addr=0x0007 with PSLVERR=1 on the PREADY cycle -> rsp_err=1; the next transfer has rsp_err=0.
- Back-to-back: rsp_ready=1 and a second req_valid in the RESP cycle -> req_ready=1 in that cycle, PSEL low for exactly 1 cycle, second SETUP in the next cycle.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, PSEL=0.
- Reset during ACCESS (PREADY held 0), then with APB4_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16 a stuck PREADY=0 -> after reset PSEL=PENABLE=rsp_valid=0 next cycle; timeout case gives rsp_err=1 after 16 wait cycles.
